// File: rtl/systolic_result_drain.sv
// systolic_result_drain
//   Captures the result vector of the NxN systolic array on the rising edge of
//   done_matrix_mult_i and streams the N*N elements out row-major, one per
//   valid/ready beat. After the final beat it pulses array_clear_o for one cycle
//   so the top level can return the array to idle.
//
// Ports
//   clk                 clock, rising edge
//   reset               synchronous, active-high reset
//   y_i                 result vector; element k sits at y_i[(N*N-k)*ELEM_W-1 -: ELEM_W]
//   done_matrix_mult_i  done level from the array
//   out_data_o          current element
//   out_idx_o           index k of out_data_o
//   out_valid_o         out_data_o / out_idx_o / out_last_o are valid
//   out_ready_i         consumer accepts when high with out_valid_o
//   out_last_o          high with the final element
//   array_clear_o       one-cycle pulse after the final beat
//   busy_o              high whenever not idle
//   overrun_o           sticky: done rose again while not idle
module systolic_result_drain #(
  parameter int unsigned N      = 4,
  parameter int unsigned ELEM_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N*N*ELEM_W-1:0]     y_i,
  input  logic                      done_matrix_mult_i,
  output logic [ELEM_W-1:0]         out_data_o,
  output logic [$clog2(N*N)-1:0]    out_idx_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      out_last_o,
  output logic                      array_clear_o,
  output logic                      busy_o,
  output logic                      overrun_o
);

  localparam int unsigned NumElem = N * N;
  localparam int unsigned IdxW    = $clog2(NumElem);
  localparam int unsigned VecW    = NumElem * ELEM_W;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumElem - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StClear
  } state_e;

  state_e            state_q;
  logic              done_q;
  logic [VecW-1:0]   shift_q;
  logic [IdxW-1:0]   cnt_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              array_clear_q;
  logic              busy_q;
  logic              overrun_q;

  logic              done_rise;
  logic              beat;
  logic [IdxW-1:0]   cnt_inc;

  assign done_rise = done_matrix_mult_i & ~done_q;
  assign beat      = out_valid_q & out_ready_i;
  assign cnt_inc   = cnt_q + IdxW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      // Starts high so a done level held across reset is not taken as a new edge.
      done_q        <= 1'b1;
      shift_q       <= '0;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      array_clear_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      done_q <= done_matrix_mult_i;

      // A second result while one is still in flight is dropped and flagged.
      if (done_rise && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (done_rise) begin
            state_q     <= StDrain;
            shift_q     <= y_i;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= (LastIdx == '0);
            busy_q      <= 1'b1;
          end
        end
        StDrain: begin
          if (beat) begin
            if (out_last_q) begin
              state_q       <= StClear;
              out_valid_q   <= 1'b0;
              out_last_q    <= 1'b0;
              array_clear_q <= 1'b1;
              cnt_q         <= '0;
              shift_q       <= '0;
            end else begin
              shift_q    <= shift_q << ELEM_W;
              cnt_q      <= cnt_inc;
              out_last_q <= (cnt_inc == LastIdx);
            end
          end
        end
        StClear: begin
          state_q       <= StIdle;
          array_clear_q <= 1'b0;
          busy_q        <= 1'b0;
        end
        default: begin
          state_q       <= StIdle;
          out_valid_q   <= 1'b0;
          out_last_q    <= 1'b0;
          array_clear_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  // Element 0 lives in the MSBs; the register shifts left once per beat.
  assign out_data_o    = shift_q[VecW-1 -: ELEM_W];
  assign out_idx_o     = cnt_q;
  assign out_valid_o   = out_valid_q;
  assign out_last_o    = out_last_q;
  assign array_clear_o = array_clear_q;
  assign busy_o        = busy_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
module tb_systolic_result_drain;

  localparam int N      = 4;
  localparam int ELEM_W = 32;
  localparam int NN     = N * N;
  localparam int IW     = $clog2(NN);

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NN*ELEM_W-1:0]   y;
  logic                   done;
  logic [ELEM_W-1:0]      out_data;
  logic [IW-1:0]          out_idx;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic                   array_clear;
  logic                   busy;
  logic                   overrun;

  systolic_result_drain #(.N(N), .ELEM_W(ELEM_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .y_i                (y),
    .done_matrix_mult_i (done),
    .out_data_o         (out_data),
    .out_idx_o          (out_idx),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .out_last_o         (out_last),
    .array_clear_o      (array_clear),
    .busy_o             (busy),
    .overrun_o          (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ELEM_W-1:0] data;
    int                idx;
    logic              last;
  } exp_t;

  exp_t              exp_q[$];
  logic [ELEM_W-1:0] elems[NN];
  int tests  = 0;
  int fails  = 0;
  int beats  = 0;
  int clears = 0;
  int exp_clears = 0;
  int ready_mode = 0;
  int rphase = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consumer: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (rphase == 0);
          rphase = (rphase + 1) % 3;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: whatever the DUT presents must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: idx %0d data %h, expected no output", out_idx, out_data);
        end else begin
          check("out_data", out_data, exp_q[0].data);
          check("out_idx", out_idx, exp_q[0].idx);
          check("out_last", out_last, exp_q[0].last);
          if (out_ready) begin
            void'(exp_q.pop_front());
            beats++;
          end
        end
      end
      if (array_clear) begin
        clears++;
        check("clear_after_last", exp_q.size(), 0);
      end
    end
  end

  // Drive y from elems and raise done; when a capture is expected, queue the stream.
  task automatic raise_done(input bit expect_capture);
    @(posedge clk);
    #1;
    for (int k = 0; k < NN; k++) begin
      y[(NN-k)*ELEM_W-1 -: ELEM_W] = elems[k];
    end
    done = 1'b1;
    if (expect_capture) begin
      for (int k = 0; k < NN; k++) begin
        exp_t e;
        e.data = elems[k];
        e.idx  = k;
        e.last = (k == NN - 1);
        exp_q.push_back(e);
      end
      exp_clears++;
    end
  endtask

  task automatic lower_done();
    @(posedge clk);
    #1;
    done = 1'b0;
  endtask

  task automatic wait_clear(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!array_clear && cyc < budget);
    if (!array_clear) begin
      tests++;
      fails++;
      $display("FAIL clear_timeout: no array_clear within %0d cycles, expected one", budget);
    end
  endtask

  task automatic wait_beats(input int base, input int n, input int budget);
    int c = 0;
    while ((beats - base) < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if ((beats - base) < n) begin
      tests++;
      fails++;
      $display("FAIL beat_timeout: saw %0d beats, expected %0d", beats - base, n);
    end
  endtask

  task automatic rand_elems();
    for (int k = 0; k < NN; k++) elems[k] = $urandom;
  endtask

  initial begin
    int cyc, c0, b0;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, c0, b0;
    reset = 1'b1;
    done  = 1'b0;
    y     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_idx", out_idx, 0);
    check("rst_data", out_data, 0);
    check("rst_clear", array_clear, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);

    // Basic drain with full-rate consumer; latency from sampled rise to clear is 17.
    ready_mode = 0;
    for (int k = 0; k < NN; k++) elems[k] = 32'h1000_0000 + k;
    raise_done(1);
    @(posedge clk);
    wait_clear(40, cyc);
    check("clear_latency", cyc, 17);
    @(negedge clk);
    check("clear_one_cycle", array_clear, 0);
    check("idle_after_clear", busy, 0);
    check("basic_drained", exp_q.size(), 0);
    lower_done();

    // Backpressure 1,0,0 pattern.
    ready_mode = 1;
    rand_elems();
    raise_done(1);
    wait_clear(200, cyc);
    check("bp_drained", exp_q.size(), 0);
    check("bp_overrun", overrun, 0);
    lower_done();

    // Done held high for 40 cycles: exactly one stream.
    ready_mode = 0;
    rand_elems();
    c0 = clears;
    b0 = beats;
    raise_done(1);
    repeat (40) @(negedge clk);
    check("held_clears", clears - c0, 1);
    check("held_beats", beats - b0, NN);
    check("held_overrun", overrun, 0);
    lower_done();

    // Overrun: re-raise done at beat 5; original stream must still complete.
    ready_mode = 1;
    rand_elems();
    b0 = beats;
    c0 = clears;
    raise_done(1);
    wait_beats(b0, 5, 100);
    lower_done();
    rand_elems();
    raise_done(0);
    wait_clear(200, cyc);
    check("ovr_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("ovr_flag", overrun, 1);
    check("ovr_clears", clears - c0, 1);
    lower_done();
    repeat (3) @(negedge clk);
    check("ovr_sticky", overrun, 1);

    // Reset mid-drain with done held high.
    ready_mode = 0;
    rand_elems();
    b0 = beats;
    raise_done(1);
    wait_beats(b0, 8, 100);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    exp_clears--;
    #1;
    reset = 1'b0;
    c0 = clears;
    @(negedge clk);
    check("rmd_valid", out_valid, 0);
    check("rmd_busy", busy, 0);
    check("rmd_overrun", overrun, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rmd_no_recapture", busy, 0);
    end
    check("rmd_no_clear", clears - c0, 0);
    lower_done();
    rand_elems();
    raise_done(1);
    wait_clear(40, cyc);
    check("rmd_recapture", exp_q.size(), 0);

    // Back-to-back: new rise two cycles after the clear pulse.
    @(posedge clk);
    #1;
    done = 1'b0;
    for (int k = 0; k < NN; k++) elems[k] = 32'hFFFF_FFFF;
    raise_done(1);
    wait_clear(40, cyc);
    check("b2b_latency", cyc, 18);
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_overrun", overrun, 0);
    lower_done();

    // Random streams with a random consumer.
    ready_mode = 2;
    for (int r = 0; r < 5; r++) begin
      rand_elems();
      raise_done(1);
      wait_clear(300, cyc);
      lower_done();
      repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    repeat (4) @(negedge clk);
    check("total_clears", clears, exp_clears);
    check("final_queue", exp_q.size(), 0);
    check("final_overrun", overrun, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
